// File: rtl/mem_responder.sv
// Memory-side responder for the CPU MAR/MDR datapath: one request at a time,
// serviced from on-chip word RAM or the memory-mapped I/O word, ending in a one-cycle R pulse.
module mem_responder #(
    parameter int          ADDR_W   = 10,
    parameter int          WAIT_CYC = 2,
    parameter logic [15:0] IO_ADDR  = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MEM_EN,
    input  logic        WE,
    input  logic [15:0] ADDR,
    input  logic [15:0] DATA_IN,
    input  logic [15:0] SW,
    output logic [15:0] DATA_OUT,
    output logic        R,
    output logic [15:0] HEX_OUT
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

    localparam int          RAM_DEPTH = 2 ** ADDR_W;
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYC);

    state_t             state_q;
    logic               armed_q;
    logic               we_q;
    logic [15:0]        addr_q;
    logic [15:0]        addr_d;
    logic [15:0]        data_q;
    logic [3:0]         cnt_q;
    logic               accept;
    logic               in_ram;
    logic               ram_we;
    logic [15:0]        ram_rd_q;
    logic [15:0]        mem [RAM_DEPTH];

    assign accept = (state_q == S_IDLE) && MEM_EN && armed_q;
    assign addr_d = accept ? ADDR : addr_q;
    assign in_ram = (addr_q >> ADDR_W) == 16'd0;
    // Reset wins over a write landing on the same edge, so an aborted store never lands.
    assign ram_we = !Reset && (state_q == S_ACCESS) && we_q && in_ram;

    // Read port follows the address being captured, so the word is ready by the ACCESS edge.
    always_ff @(posedge Clk) begin
        if (ram_we) begin
            mem[addr_q[ADDR_W-1:0]] <= data_q;
        end
        ram_rd_q <= mem[addr_d[ADDR_W-1:0]];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            R        <= 1'b0;
            DATA_OUT <= 16'h0000;
            HEX_OUT  <= 16'h0000;
            armed_q  <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= 16'h0000;
            data_q   <= 16'h0000;
            cnt_q    <= 4'd0;
        end else begin
            R      <= 1'b0;
            addr_q <= addr_d;
            case (state_q)
                S_IDLE: begin
                    if (!MEM_EN) begin
                        armed_q <= 1'b1;
                    end else if (armed_q) begin
                        we_q    <= WE;
                        data_q  <= DATA_IN;
                        armed_q <= 1'b0;
                        cnt_q   <= 4'd0;
                        state_q <= (WAIT_CYC > 0) ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == WAIT_LAST) begin
                        state_q <= S_ACCESS;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_ACCESS: begin
                    if (!we_q) begin
                        if (in_ram) begin
                            DATA_OUT <= ram_rd_q;
                        end else if (addr_q == IO_ADDR) begin
                            DATA_OUT <= SW;
                        end else begin
                            DATA_OUT <= 16'h0000;
                        end
                    end else if (!in_ram && (addr_q == IO_ADDR)) begin
                        HEX_OUT <= data_q;
                    end
                    R       <= 1'b1;
                    state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed cases plus random traffic
// checked against a word-array model of RAM, I/O word and read register.
module tb_mem_responder;
    localparam int WAIT_CYC = 2;
    localparam int LAT      = WAIT_CYC + 2;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        MEM_EN = 1'b0;
    logic        WE = 1'b0;
    logic [15:0] ADDR = 16'h0000;
    logic [15:0] DATA_IN = 16'h0000;
    logic [15:0] SW = 16'h0000;
    logic [15:0] DATA_OUT;
    logic        R;
    logic [15:0] HEX_OUT;

    int compared = 0;
    int mismatched = 0;

    logic [15:0] mref [1024];
    logic [15:0] dout_ref = 16'h0000;
    logic [15:0] hex_ref = 16'h0000;

    always #5 Clk = ~Clk;

    mem_responder #(.ADDR_W(10), .WAIT_CYC(WAIT_CYC), .IO_ADDR(16'hFFFF)) dut (
        .Clk(Clk), .Reset(Reset), .MEM_EN(MEM_EN), .WE(WE), .ADDR(ADDR),
        .DATA_IN(DATA_IN), .SW(SW), .DATA_OUT(DATA_OUT), .R(R), .HEX_OUT(HEX_OUT)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete request; hold = extra cycles MEM_EN stays high after R, scr = scramble inputs mid-flight.
    task automatic txn(input logic we, input logic [15:0] a, input logic [15:0] d,
                       input int hold, input bit scr);
        int   edge_n;
        bit   seen;
        logic [15:0] sw_v;
        sw_v = 16'($urandom);
        @(negedge Clk);
        MEM_EN = 1'b1; WE = we; ADDR = a; DATA_IN = d; SW = sw_v;
        edge_n = -1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge Clk);
            #1;
            edge_n++;
            if (R) seen = 1'b1;
            else if (scr) begin
                ADDR = 16'($urandom); DATA_IN = 16'($urandom);
                WE = 1'($urandom); MEM_EN = 1'($urandom);
            end
        end
        if (we) begin
            if (a < 16'd1024) mref[a[9:0]] = d;
            else if (a == 16'hFFFF) hex_ref = d;
        end else begin
            if (a < 16'd1024) dout_ref = mref[a[9:0]];
            else if (a == 16'hFFFF) dout_ref = sw_v;
            else dout_ref = 16'h0000;
        end
        chk("R_latency", 16'(seen ? edge_n : 99), 16'(LAT));
        chk("DATA_OUT_at_R", DATA_OUT, dout_ref);
        chk("HEX_OUT_at_R", HEX_OUT, hex_ref);
        $display("txn we=%0d addr=%h data=%h sw=%h -> dout=%h hex=%h", we, a, d, sw_v, DATA_OUT, HEX_OUT);
        MEM_EN = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge Clk);
            #1;
            chk("R_held_strobe", {15'd0, R}, 16'd0);
        end
        @(negedge Clk);
        MEM_EN = 1'b0;
        ADDR = 16'($urandom); DATA_IN = 16'($urandom);
        @(posedge Clk);
        #1;
        chk("R_one_cycle", {15'd0, R}, 16'd0);
        chk("DATA_OUT_hold", DATA_OUT, dout_ref);
        if (hold == 0) @(posedge Clk);
    endtask

    function automatic logic [15:0] pick_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 5) return (r == 5) ? 16'h03FF : 16'($urandom_range(0, 31));
        if (r <= 7) return 16'hFFFF;
        if (r == 8) return 16'($urandom_range(16'h0400, 16'hFFFE));
        return 16'h0800;
    endfunction

    initial begin
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_R", {15'd0, R}, 16'd0);
        chk("reset_DATA_OUT", DATA_OUT, 16'h0000);
        chk("reset_HEX_OUT", HEX_OUT, 16'h0000);
        @(negedge Clk);
        Reset = 1'b0;

        // Known contents for every RAM word the bench later reads.
        for (int i = 0; i < 32; i++) txn(1'b1, 16'(i), 16'($urandom), 0, 1'b0);
        txn(1'b1, 16'h03FF, 16'($urandom), 0, 1'b0);

        txn(1'b1, 16'h0010, 16'hBEEF, 0, 1'b0);
        txn(1'b0, 16'h0010, 16'h0000, 0, 1'b0);
        chk("read_back_BEEF", DATA_OUT, 16'hBEEF);

        txn(1'b0, 16'hFFFF, 16'h0000, 0, 1'b0);
        txn(1'b1, 16'hFFFF, 16'h00A5, 0, 1'b0);
        chk("hex_00A5", HEX_OUT, 16'h00A5);
        txn(1'b0, 16'h03FF, 16'h0000, 0, 1'b0);

        txn(1'b0, 16'h0800, 16'h0000, 0, 1'b0);
        txn(1'b1, 16'h0800, 16'hFFFF, 0, 1'b0);
        txn(1'b0, 16'h0000, 16'h0000, 0, 1'b0);

        // Strobe held across DONE: no second pulse, then a fresh request after one low cycle.
        txn(1'b1, 16'h0005, 16'h1357, 10, 1'b0);
        txn(1'b0, 16'h0005, 16'h0000, 0, 1'b0);

        // Reset during WAIT of a write aborts it.
        @(negedge Clk);
        MEM_EN = 1'b1; WE = 1'b1; ADDR = 16'h0003; DATA_IN = 16'h5555;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        dout_ref = 16'h0000;
        hex_ref = 16'h0000;
        chk("abort_R", {15'd0, R}, 16'd0);
        chk("abort_DATA_OUT", DATA_OUT, dout_ref);
        chk("abort_HEX_OUT", HEX_OUT, hex_ref);
        @(negedge Clk);
        Reset = 1'b0;
        MEM_EN = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk);
            #1;
            chk("abort_no_R", {15'd0, R}, 16'd0);
        end
        txn(1'b0, 16'h0003, 16'h0000, 0, 1'b0);

        // Inputs scrambled mid-flight: captured values must be used.
        txn(1'b1, 16'h0007, 16'hC0DE, 0, 1'b1);
        txn(1'b0, 16'h0007, 16'h0000, 0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            txn(1'($urandom), pick_addr(), 16'($urandom), $urandom_range(0, 2), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
